alu: RTL and testbench



---
 rtl/alu.sv | 244 ++++++++++++++++++++++++
 tb/tb_alu.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//
// 32-bit arithmetic/logic unit for the single-cycle datapath project.
// Seven operations are purely combinational (AND, OR, XOR, NOR, signed
// less-than, add with carry-in, subtract). The eighth, unsigned modulo, is a
// multi-cycle repeated-subtraction engine with a start/done handshake. The
// engine runs independently of sel; sel only picks what appears on result.
//
// Ports
//   clk     in   1   system clock, all state updates on the rising edge
//   reset   in   1   synchronous active-high reset of the modulo engine
//   a       in  32   operand A
//   b       in  32   operand B
//   sel     in   3   operation select
//   c_in    in   1   carry-in, used by add only
//   start   in   1   modulo start request, level-sensitive
//   result  out 32   selected operation result
//   c_out   out  1   carry-out of add/subtract, 0 for every other op
//   done    out  1   modulo remainder valid (high only in the DONE state)
// ---------------------------------------------------------------------------
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  sel,
  input  logic        c_in,
  input  logic        start,
  output logic [31:0] result,
  output logic        c_out,
  output logic        done
);

  // Operation encodings for the result multiplexer.
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  // Modulo engine states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] div_q, div_d;

  logic        load_en;
  logic        zero_div_load;
  logic        sub_en;

  logic [31:0] and_res;
  logic [31:0] or_res;
  logic [31:0] xor_res;
  logic [31:0] nor_res;
  logic [31:0] slt_res;
  logic [32:0] add_sum;
  logic [32:0] sub_sum;

  logic [32:0] mod_diff;
  logic        rem_ge_div;

  // -------------------------------------------------------------------------
  // Bitwise logic unit. All four results are always computed; the mux below
  // chooses which one is visible.
  // -------------------------------------------------------------------------
  always_comb begin
    and_res = a & b;
    or_res  = a | b;
    xor_res = a ^ b;
    nor_res = ~(a | b);
  end

  // -------------------------------------------------------------------------
  // Signed comparison. The result is a full 32-bit word holding 0 or 1 so it
  // can be written straight into a register by the datapath.
  // -------------------------------------------------------------------------
  always_comb begin
    slt_res = 32'd0;
    if ($signed(a) < $signed(b)) begin
      slt_res = 32'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Adder and subtractor, both 33 bits wide so the top bit is the carry-out.
  // Subtract uses two's complement (a + ~b + 1) and ignores c_in, so a carry
  // of 1 means no borrow, i.e. a >= b as unsigned numbers.
  // -------------------------------------------------------------------------
  always_comb begin
    add_sum = {1'b0, a} + {1'b0, b} + {32'd0, c_in};
    sub_sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
  end

  // -------------------------------------------------------------------------
  // Modulo engine subtractor. One subtractor produces both the next remainder
  // and the unsigned rem >= div decision (carry-out set means no borrow), so
  // the compare and the subtract in CALC always agree.
  // -------------------------------------------------------------------------
  always_comb begin
    mod_diff   = {1'b0, rem_q} + {1'b0, ~div_q} + 33'd1;
    rem_ge_div = mod_diff[32];
  end

  // -------------------------------------------------------------------------
  // Modulo FSM next-state logic.
  // IDLE waits for start; a zero divisor skips CALC and finishes at once with
  // the dividend as the remainder. CALC loops while another subtraction fits.
  // DONE holds while start stays high so a held start cannot retrigger; a new
  // run needs start low for at least one edge to get back through IDLE.
  // start seen during CALC is ignored.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (b == 32'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (!rem_ge_div) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Modulo FSM output logic. Produces the handshake output and the datapath
  // enables from the current state and inputs.
  // -------------------------------------------------------------------------
  always_comb begin
    done          = 1'b0;
    load_en       = 1'b0;
    zero_div_load = 1'b0;
    sub_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_en       = 1'b1;
          zero_div_load = (b == 32'd0);
        end
      end
      ST_CALC: begin
        sub_en = rem_ge_div;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Modulo datapath next values. Operands are captured on the load edge only,
  // so later changes on a/b cannot disturb a computation in progress. With a
  // zero divisor only rem is loaded; div keeps whatever it held. The
  // remainder is otherwise held in IDLE and DONE so sel 111 stays readable.
  // -------------------------------------------------------------------------
  always_comb begin
    rem_d = rem_q;
    div_d = div_q;
    if (load_en) begin
      rem_d = a;
      if (!zero_div_load) begin
        div_d = b;
      end
    end else if (sub_en) begin
      rem_d = mod_diff[31:0];
    end
  end

  // -------------------------------------------------------------------------
  // State register for the modulo engine. Reset has top priority and may
  // land in any state, including mid-CALC or DONE.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= 32'd0;
      div_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
    end
  end

  // -------------------------------------------------------------------------
  // Result multiplexer. c_out is only meaningful for add and subtract and is
  // forced to 0 for every other operation.
  // -------------------------------------------------------------------------
  always_comb begin
    result = 32'd0;
    c_out  = 1'b0;
    case (sel)
      OP_AND: result = and_res;
      OP_OR:  result = or_res;
      OP_XOR: result = xor_res;
      OP_NOR: result = nor_res;
      OP_SLT: result = slt_res;
      OP_ADD: begin
        result = add_sum[31:0];
        c_out  = add_sum[32];
      end
      OP_SUB: begin
        result = sub_sum[31:0];
        c_out  = sub_sum[32];
      end
      OP_MOD: result = rem_q;
      default: begin
        result = 32'd0;
        c_out  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu
//
// Directed self-checking bench for alu. Combinational ops are checked with
// hand-computed vectors; the modulo engine is checked for edge-exact latency,
// handshake behaviour, zero divisor, a < b, and reset in the middle of a run.
// ---------------------------------------------------------------------------
module tb_alu;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  sel;
  logic        c_in;
  logic        start;
  logic [31:0] result;
  logic        c_out;
  logic        done;

  int checks;
  int errors;
  int edges;

  alu dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .sel    (sel),
    .c_in   (c_in),
    .start  (start),
    .result (result),
    .c_out  (c_out),
    .done   (done)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives the combinational operand inputs and lets them settle.
  task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb,
                               input logic [2:0] tsel, input logic tc);
    a    = ta;
    b    = tb;
    sel  = tsel;
    c_in = tc;
    #1;
  endtask

  // One comparison: counts it, and on mismatch counts the error and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Counts rising edges until done rises, bounded by limit; settles #1 after
  // each edge before sampling.
  task automatic waitDone(input int limit, output int count);
    count = 0;
    while (done !== 1'b1 && count < limit) begin
      @(posedge clk);
      #1;
      count++;
    end
  endtask

  // Synchronous reset pulse of one edge, released away from the edge.
  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    start  = 1'b0;
    a      = 32'd0;
    b      = 32'd0;
    sel    = 3'b000;
    c_in   = 1'b0;

    pulseReset();

    // Reset state of the modulo engine.
    applyStimulus(32'd0, 32'd0, 3'b111, 1'b0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_cout", {31'd0, c_out}, 32'd0);

    // Combinational ops with a=100, b=60.
    applyStimulus(32'd100, 32'd60, 3'b000, 1'b0);
    checkOutput("and", result, 32'd36);
    applyStimulus(32'd100, 32'd60, 3'b001, 1'b0);
    checkOutput("or", result, 32'd124);
    applyStimulus(32'd100, 32'd60, 3'b010, 1'b0);
    checkOutput("xor", result, 32'd88);
    applyStimulus(32'd100, 32'd60, 3'b011, 1'b0);
    checkOutput("nor", result, 32'hFFFFFF83);
    checkOutput("nor_cout", {31'd0, c_out}, 32'd0);
    applyStimulus(32'd100, 32'd60, 3'b100, 1'b0);
    checkOutput("slt", result, 32'd0);
    applyStimulus(32'd100, 32'd60, 3'b101, 1'b0);
    checkOutput("add", result, 32'd160);
    checkOutput("add_cout", {31'd0, c_out}, 32'd0);
    applyStimulus(32'd100, 32'd60, 3'b110, 1'b0);
    checkOutput("sub", result, 32'd40);
    checkOutput("sub_cout", {31'd0, c_out}, 32'd1);

    // Carry and sign corners.
    applyStimulus(32'hFFFFFFFF, 32'd1, 3'b101, 1'b1);
    checkOutput("add_carry", result, 32'd1);
    checkOutput("add_carry_cout", {31'd0, c_out}, 32'd1);
    applyStimulus(32'd0, 32'd1, 3'b110, 1'b1);
    checkOutput("sub_borrow", result, 32'hFFFFFFFF);
    checkOutput("sub_borrow_cout", {31'd0, c_out}, 32'd0);
    applyStimulus(32'hFFFFFFFF, 32'd1, 3'b100, 1'b0);
    checkOutput("slt_neg", result, 32'd1);
    applyStimulus(32'd1, 32'hFFFFFFFF, 3'b100, 1'b0);
    checkOutput("slt_pos", result, 32'd0);
    applyStimulus(32'd7, 32'd9, 3'b101, 1'b1);
    checkOutput("add_cin", result, 32'd17);

    // Modulo 100 mod 6: done exactly 18 edges after the start-sampling edge.
    pulseReset();
    applyStimulus(32'd100, 32'd6, 3'b111, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    edges = 1;
    // Operands change after the load edge; the engine must not care.
    a = 32'd12345;
    b = 32'd0;
    // sel change mid-CALC just reroutes the mux.
    sel = 3'b000;
    #1;
    checkOutput("mid_calc_and", result, 32'd0);
    sel = 3'b111;
    #1;
    begin
      int more;
      waitDone(100, more);
      edges = edges + more;
    end
    checkOutput("mod100_6_latency", edges, 32'd18);
    checkOutput("mod100_6_result", result, 32'd4);
    checkOutput("mod_cout", {31'd0, c_out}, 32'd0);
    // Held start keeps done high and does not retrigger.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_held", {31'd0, done}, 32'd1);
    checkOutput("held_result", result, 32'd4);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("done_fall", {31'd0, done}, 32'd0);
    checkOutput("result_kept", result, 32'd4);

    // a < b: done after 2 edges with the dividend as remainder.
    @(negedge clk);
    applyStimulus(32'd5, 32'd9, 3'b111, 1'b0);
    start = 1'b1;
    waitDone(10, edges);
    checkOutput("mod5_9_latency", edges, 32'd2);
    checkOutput("mod5_9_result", result, 32'd5);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;

    // Zero divisor: done after 1 edge with result = a.
    @(negedge clk);
    applyStimulus(32'd77, 32'd0, 3'b111, 1'b0);
    start = 1'b1;
    waitDone(10, edges);
    checkOutput("mod_b0_latency", edges, 32'd1);
    checkOutput("mod_b0_result", result, 32'd77);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of a long run.
    @(negedge clk);
    applyStimulus(32'd1000, 32'd3, 3'b111, 1'b0);
    start = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_done", {31'd0, done}, 32'd0);
    checkOutput("midrst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_idle", {31'd0, done}, 32'd0);
    checkOutput("midrst_rem_held", result, 32'd0);

    // Restart after start has been low: 1000 mod 3 = 1 after 333+2 edges.
    @(negedge clk);
    start = 1'b1;
    waitDone(500, edges);
    checkOutput("mod1000_3_latency", edges, 32'd335);
    checkOutput("mod1000_3_result", result, 32'd1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("final_done_fall", {31'd0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
